// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder FSM: wait for a request, count latency, acknowledge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } dmem_state_t;

    localparam int LINE_W   = 256;  // cache line width in bits
    localparam int OFFSET_W = 5;    // byte offset bits within a line
    localparam int CNT_W    = 8;    // latency counter width (LATENCY <= 255)

endpackage

// File: rtl/dmem_line_array.sv
// Line storage: synchronous write, asynchronous read, one shared line index.
// Kept apart from the FSM so a vendor RAM can replace it.
module dmem_line_array #(
    parameter int LINE_W = 256,
    parameter int DEPTH  = 512
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [LINE_W-1:0]        wdata_i,
    output logic [LINE_W-1:0]        rdata_o
);

    // Contents are deliberately never reset.
    logic [LINE_W-1:0] mem_q [DEPTH];

    // Commit one line per write-enabled edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency line read/write responder behind the data cache memory port.
//
// Handshake: a request is taken on any rising edge where enable_i=1 and the
// FSM is IDLE; the addr/write/data values at that edge are latched and later
// input activity is ignored. Exactly LATENCY edges after acceptance, ack_o is
// high for one cycle with data_o holding the read line (or the echoed write
// line); data_o is 0 whenever ack_o is 0. A write reaches the array on the
// same edge that raises ack_o, so any later-accepted read observes it.
module dmem_responder #(
    parameter int LINE_W  = dmem_pkg::LINE_W,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    input  logic [31:0]           addr_i,
    input  logic [LINE_W-1:0]     data_i,
    output logic                  ack_o,
    output logic [LINE_W-1:0]     data_o,
    output dmem_pkg::dmem_state_t state_o
);

    import dmem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;
    logic              ack_q;
    logic [LINE_W-1:0] rdata_q;

    logic [IDX_W-1:0]  req_idx;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_we;
    logic              unused_addr;

    // Upper bits are dropped so addresses wrap over the array; offset ignored.
    assign req_idx     = addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
    assign unused_addr = ^{addr_i[31:IDX_W+OFFSET_W], addr_i[OFFSET_W-1:0]};

    // The ACK state is the last cycle of a transaction: commit writes then.
    assign mem_we = (state_q == ACK) && wr_q;

    dmem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // FSM, latency counter, request latch and registered ack/data outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        wr_q    <= write_i;
                        idx_q   <= req_idx;
                        wdata_q <= data_i;
                        if (LATENCY == 1) begin
                            cnt_q   <= '0;
                            state_q <= ACK;
                        end else begin
                            cnt_q   <= CNT_W'(LATENCY - 1);
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b1;
                    rdata_q <= wr_q ? wdata_q : mem_rdata;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign data_o  = rdata_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: one LATENCY=10 responder for the main scenarios and a
// LATENCY=1 responder for back-to-back traffic, both checked against a
// behavioural line-memory model with an expected-data queue.
module tb_dmem_responder;

    localparam int LW    = dmem_pkg::LINE_W;
    localparam int DEPTH = 512;
    localparam int LAT_A = 10;
    localparam int LAT_B = 1;

    typedef logic [LW-1:0] line_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (LATENCY=10) ----------------
    logic                  a_en, a_wr, a_ack;
    logic [31:0]           a_addr;
    line_t                 a_wdata, a_rdata;
    dmem_pkg::dmem_state_t a_state;

    dmem_responder #(.LINE_W(LW), .DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .enable_i (a_en),
        .write_i  (a_wr),
        .addr_i   (a_addr),
        .data_i   (a_wdata),
        .ack_o    (a_ack),
        .data_o   (a_rdata),
        .state_o  (a_state)
    );

    // ---------------- DUT B (LATENCY=1) ----------------
    logic                  b_en, b_wr, b_ack;
    logic [31:0]           b_addr;
    line_t                 b_wdata, b_rdata;
    dmem_pkg::dmem_state_t b_state;

    dmem_responder #(.LINE_W(LW), .DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .enable_i (b_en),
        .write_i  (b_wr),
        .addr_i   (b_addr),
        .data_i   (b_wdata),
        .ack_o    (b_ack),
        .data_o   (b_rdata),
        .state_o  (b_state)
    );

    // ---------------- reference model / scoreboard ----------------
    line_t a_mem [DEPTH];
    bit    a_valid [DEPTH];
    int    a_lines[$];
    line_t b_mem [8];
    line_t exp_q[$];
    int    due_q[$];

    int total = 0;
    int bad   = 0;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 5) % DEPTH);
    endfunction

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_write_a(input logic [31:0] addr, input line_t d);
        int l;
        l = line_of(addr);
        a_mem[l] = d;
        if (!a_valid[l]) a_lines.push_back(l);
        a_valid[l] = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // One transaction on A. Reports the first ack edge offset from acceptance,
    // the number of ack cycles and of non-ack cycles with nonzero data_o.
    task automatic run_a(input bit wr, input logic [31:0] addr, input line_t wd, input bit scramble,
                         output int lat, output int acks, output int dirty, output line_t rd);
        lat = -1; acks = 0; dirty = 0; rd = '0;
        @(negedge clk);
        a_en = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wd;
        @(posedge clk); #1;
        a_en = 1'b0;
        for (int n = 1; n <= LAT_A + 3; n++) begin
            if (scramble) begin
                a_addr  = $urandom;
                a_wdata = rand_line();
                a_wr    = 1'($urandom_range(0, 1));
                a_en    = (n <= LAT_A - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(posedge clk); #1;
            if (a_ack) begin
                acks++;
                if (lat < 0) begin lat = n; rd = a_rdata; end
            end else if (a_rdata !== '0) begin
                dirty++;
            end
        end
        a_en = 1'b0;
    endtask

    // Simple write on B used to preload lines.
    task automatic write_b(input logic [31:0] addr, input line_t wd);
        @(negedge clk);
        b_en = 1'b1; b_wr = 1'b1; b_addr = addr; b_wdata = wd;
        @(posedge clk); #1;
        b_en = 1'b0;
        repeat (LAT_B + 3) @(posedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", a_ack); end
        total++; if (a_rdata !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", a_rdata); end
        total++; if (a_state !== dmem_pkg::IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", a_state, dmem_pkg::IDLE); end
        total++; if (b_ack !== 1'b0) begin bad++; $display("FAIL reset_ack_b: got %b want 0", b_ack); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency;
        int lat, acks, dirty; line_t rd;
        model_write_a(32'h60, {32{8'hA5}});
        exp_q.push_back({32{8'hA5}});
        run_a(1'b1, 32'h60, {32{8'hA5}}, 1'b0, lat, acks, dirty, rd);
        total++; if (lat !== LAT_A) begin bad++; $display("FAIL lat_write3: got %0d want %0d", lat, LAT_A); end
        total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL echo_write3: got %h", rd); end
        exp_q.push_back(a_mem[3]);
        run_a(1'b0, 32'h60, '0, 1'b0, lat, acks, dirty, rd);
        total++; if (lat !== LAT_A) begin bad++; $display("FAIL lat_read3: got %0d want %0d", lat, LAT_A); end
        total++; if (acks !== 1) begin bad++; $display("FAIL ack_width_read3: got %0d want 1", acks); end
        total++; if (dirty !== 0) begin bad++; $display("FAIL data_idle_zero: got %0d nonzero cycles want 0", dirty); end
        total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL data_read3: got %h want %h", rd, a_mem[3]); end
    endtask

    task automatic test_write_read;
        int lat, acks, dirty; line_t rd;
        model_write_a(32'hE0, {8{32'hDEADBEEF}});
        run_a(1'b1, 32'hE0, {8{32'hDEADBEEF}}, 1'b0, lat, acks, dirty, rd);
        total++; if (lat !== LAT_A) begin bad++; $display("FAIL lat_write7: got %0d want %0d", lat, LAT_A); end
        exp_q.push_back(a_mem[7]);
        run_a(1'b0, 32'hE0, '0, 1'b0, lat, acks, dirty, rd);
        total++; if (lat !== LAT_A) begin bad++; $display("FAIL lat_read7: got %0d want %0d", lat, LAT_A); end
        total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL data_read7: got %h want %h", rd, a_mem[7]); end
    endtask

    task automatic test_wrap_offset;
        int lat, acks, dirty; line_t rd;
        exp_q.push_back(a_mem[line_of(32'h4060)]);
        run_a(1'b0, 32'h4060, '0, 1'b0, lat, acks, dirty, rd);
        total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL wrap_4060: got %h want %h", rd, a_mem[3]); end
        exp_q.push_back(a_mem[line_of(32'h7F)]);
        run_a(1'b0, 32'h7F, '0, 1'b0, lat, acks, dirty, rd);
        total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL offset_7f: got %h want %h", rd, a_mem[3]); end
    endtask

    task automatic test_midflight;
        int lat, acks, dirty; line_t rd, wd;
        wd = rand_line();
        model_write_a(32'h280, wd);
        run_a(1'b1, 32'h280, wd, 1'b1, lat, acks, dirty, rd);
        total++; if (lat !== LAT_A || acks !== 1) begin bad++; $display("FAIL mid_write_ack: got lat=%0d acks=%0d want %0d/1", lat, acks, LAT_A); end
        exp_q.push_back(a_mem[20]);
        run_a(1'b0, 32'h280, '0, 1'b1, lat, acks, dirty, rd);
        total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL mid_read20: got %h want %h", rd, a_mem[20]); end
        exp_q.push_back(a_mem[3]);
        run_a(1'b0, 32'h60, '0, 1'b1, lat, acks, dirty, rd);
        total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL mid_line3_intact: got %h want %h", rd, a_mem[3]); end
    endtask

    task automatic test_reset_mid_write;
        int lat, acks, dirty, seen; line_t rd, old_v;
        old_v = rand_line();
        model_write_a(32'h120, old_v);
        run_a(1'b1, 32'h120, old_v, 1'b0, lat, acks, dirty, rd);
        seen = 0;
        @(negedge clk);
        a_en = 1'b1; a_wr = 1'b1; a_addr = 32'h120; a_wdata = ~old_v;
        @(posedge clk); #1;
        a_en = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (a_ack) seen++; end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (a_state !== dmem_pkg::IDLE) begin bad++; $display("FAIL rst_mid_state: got %0d want %0d", a_state, dmem_pkg::IDLE); end
        repeat (LAT_A + 2) begin
            @(posedge clk); #1;
            if (a_ack) seen++;
        end
        total++; if (a_rdata !== '0) begin bad++; $display("FAIL rst_mid_data: got %h want 0", a_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; if (a_ack) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", seen); end
        exp_q.push_back(a_mem[9]);
        run_a(1'b0, 32'h120, '0, 1'b0, lat, acks, dirty, rd);
        total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL rst_mid_line9_kept: got %h want %h", rd, a_mem[9]); end
    endtask

    task automatic test_random;
        int lat, acks, dirty, l; line_t rd, wd; logic [31:0] addr; bit wr;
        for (int i = 0; i < 12; i++) begin
            wr = (a_lines.size() == 0) || ($urandom_range(0, 2) == 0);
            if (wr) begin
                addr = $urandom;
                wd   = rand_line();
                exp_q.push_back(wd);
                model_write_a(addr, wd);
            end else begin
                l    = a_lines[$urandom_range(0, a_lines.size() - 1)];
                addr = ($urandom & 32'hFFFF_C01F) | (32'(l) << 5);
                wd   = rand_line();
                exp_q.push_back(a_mem[l]);
            end
            run_a(wr, addr, wd, 1'($urandom_range(0, 1)), lat, acks, dirty, rd);
            total++; if (lat !== LAT_A || acks !== 1) begin bad++; $display("FAIL rand_ack[%0d]: got lat=%0d acks=%0d want %0d/1", i, lat, acks, LAT_A); end
            total++; if (rd !== exp_q.pop_front()) begin bad++; $display("FAIL rand_data[%0d]: addr=%h got %h", i, addr, rd); end
        end
    endtask

    task automatic test_back_to_back;
        int next_free, ack_count; bit exp_ack;
        for (int k = 0; k < 8; k++) begin
            b_mem[k] = rand_line();
            write_b(32'(k) << 5, b_mem[k]);
        end
        next_free = 0; ack_count = 0;
        due_q.delete();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            b_en    = (t < 16);
            b_wr    = 1'b0;
            b_wdata = rand_line();
            b_addr  = (32'($urandom) & 32'hFFFF_C000) | (32'(t % 8) << 5) | 32'($urandom_range(0, 31));
            @(posedge clk);
            if (b_en && t >= next_free) begin
                exp_q.push_back(b_mem[t % 8]);
                due_q.push_back(t + LAT_B);
                next_free = t + LAT_B + 1;
            end
            #1;
            exp_ack = (due_q.size() > 0) && (due_q[0] == t);
            if (b_ack) ack_count++;
            total++; if (b_ack !== exp_ack) begin bad++; $display("FAIL b2b_ack[t=%0d]: got %b want %b", t, b_ack, exp_ack); end
            if (exp_ack) begin
                void'(due_q.pop_front());
                total++; if (b_rdata !== exp_q.pop_front()) begin bad++; $display("FAIL b2b_data[t=%0d]: got %h", t, b_rdata); end
            end
        end
        b_en = 1'b0;
        total++; if (ack_count !== 8) begin bad++; $display("FAIL b2b_count: got %0d acks want 8", ack_count); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < DEPTH; i++) a_valid[i] = 1'b0;
        test_reset();
        test_latency();
        test_write_read();
        test_wrap_offset();
        test_midflight();
        test_reset_mid_write();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time in case the DUT wedges.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
